// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg: shared pipeline types (fetch entry layout, bubble constant).
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] pc;
    logic                  predict;
    logic [DATA_WIDTH-1:0] predict_pc;
  } fetch_entry_t;

  localparam fetch_entry_t FETCH_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue: IF->ID fetch FIFO with flush; FETCH_QUEUE_BYPASS_EN enables an
// empty-queue zero-latency bypass. Rev 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [XLEN-1:0]              enq_inst,
  input  logic [XLEN-1:0]              enq_pc,
  input  logic [XLEN-1:0]              enq_predict_pc,
  input  logic                         enq_predict,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [XLEN-1:0]              deq_inst,
  output logic [XLEN-1:0]              deq_pc,
  output logic [XLEN-1:0]              deq_predict_pc,
  output logic                         deq_predict,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  fetch_entry_t  enq_entry;
  fetch_entry_t  head_entry;
  fetch_entry_t  deq_entry;
  logic          empty;
  logic          bypass_take;
  logic          do_enq;
  logic          do_deq;

  always_comb begin
    enq_entry            = FETCH_BUBBLE;
    enq_entry.inst       = enq_inst;
    enq_entry.pc         = enq_pc;
    enq_entry.predict    = enq_predict;
    enq_entry.predict_pc = enq_predict_pc;
  end

  assign empty      = (count_q == '0);
  assign enq_ready  = (count_q != FULL_CNT);
  assign head_entry = mem_q[rd_ptr_q];

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue forwards the incoming entry straight to ID; flush kills it.
  assign deq_valid   = ~flush & (empty ? enq_valid : 1'b1);
  assign bypass_take = empty & enq_valid & deq_ready & ~flush;
  assign deq_entry   = !deq_valid ? FETCH_BUBBLE :
                       (empty ? enq_entry : head_entry);
`else
  assign deq_valid   = ~empty;
  assign bypass_take = 1'b0;
  assign deq_entry   = deq_valid ? head_entry : FETCH_BUBBLE;
`endif

  assign do_enq = enq_valid & enq_ready & ~flush & ~bypass_take;
  assign do_deq = deq_valid & deq_ready & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_deq) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only slots covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wr_ptr_q] <= enq_entry;
  end

  assign deq_inst       = deq_entry.inst;
  assign deq_pc         = deq_entry.pc;
  assign deq_predict    = deq_entry.predict;
  assign deq_predict_pc = deq_entry.predict_pc;
  assign count          = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue: directed scoreboard bench for fetch_queue (DEPTH=4). Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue;
  import pipe_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             enq_valid;
  logic             enq_ready;
  logic [XLEN-1:0]  enq_inst, enq_pc, enq_predict_pc;
  logic             enq_predict;
  logic             deq_valid;
  logic             deq_ready;
  logic [XLEN-1:0]  deq_inst, deq_pc, deq_predict_pc;
  logic             deq_predict;
  logic [2:0]       count;

  int total = 0;
  int bad   = 0;
  fetch_entry_t exp_q[$];
  fetch_entry_t mon_e;
  fetch_entry_t hold_e;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_inst(enq_inst), .enq_pc(enq_pc), .enq_predict_pc(enq_predict_pc),
    .enq_predict(enq_predict),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_inst(deq_inst), .deq_pc(deq_pc), .deq_predict_pc(deq_predict_pc),
    .deq_predict(deq_predict), .count(count)
  );

  always #5 clk = ~clk;

  function automatic fetch_entry_t mk(input logic [31:0] pc);
    fetch_entry_t e;
    e.pc         = pc;
    e.inst       = {16'hC0DE, pc[15:0]};
    e.predict    = pc[2];
    e.predict_pc = pc + 32'h100;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic [31:0] pc);
    fetch_entry_t e;
    e              = mk(pc);
    enq_valid      = 1'b1;
    enq_inst       = e.inst;
    enq_pc         = e.pc;
    enq_predict    = e.predict;
    enq_predict_pc = e.predict_pc;
  endtask

  task automatic push(input logic [31:0] pc);
    set_enq(pc);
    exp_q.push_back(mk(pc));
    tick();
    enq_valid = 1'b0;
  endtask

  // Monitor: bubble encoding when idle, in-order payload on every handshake.
  always @(negedge clk) begin
    if (!deq_valid) begin
      chk("bubble", deq_inst | deq_pc | deq_predict_pc | {31'b0, deq_predict}, 32'h0);
    end else if (rst_n && deq_ready && !flush) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_deq: got pc %h expected no entry", deq_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("deq_pc",   deq_pc,         mon_e.pc);
        chk("deq_inst", deq_inst,       mon_e.inst);
        chk("deq_ppc",  deq_predict_pc, mon_e.predict_pc);
        chk("deq_pred", {31'b0, deq_predict}, {31'b0, mon_e.predict});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_inst = '0; enq_pc = '0; enq_predict_pc = '0; enq_predict = 1'b0;

    // Reset
    repeat (2) tick();
    chk("rst_count",     {29'b0, count}, 32'd0);
    chk("rst_deq_valid", {31'b0, deq_valid}, 32'd0);
    chk("rst_deq_inst",  deq_inst, 32'd0);
    chk("rst_enq_ready", {31'b0, enq_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Order and full
    deq_ready = 1'b0;
    push(32'h00); push(32'h04); push(32'h08); push(32'h0C);
    chk("full_count",     {29'b0, count}, 32'd4);
    chk("full_enq_ready", {31'b0, enq_ready}, 32'd0);
    deq_ready = 1'b1;
    repeat (4) tick();
    chk("drain1_count", {29'b0, count}, 32'd0);
    chk("drain1_valid", {31'b0, deq_valid}, 32'd0);

    // Full with simultaneous enqueue/dequeue
    deq_ready = 1'b0;
    push(32'h10); push(32'h14); push(32'h18); push(32'h1C);
    set_enq(32'h50);
    deq_ready = 1'b1;
    tick();
    chk("fsim_count1",     {29'b0, count}, 32'd3);
    chk("fsim_enq_ready",  {31'b0, enq_ready}, 32'd1);
    exp_q.push_back(mk(32'h50));
    tick();
    enq_valid = 1'b0;
    chk("fsim_count2", {29'b0, count}, 32'd3);
    repeat (3) tick();
    chk("drain2_count", {29'b0, count}, 32'd0);

    // Flush drops queued entries and the same-cycle enqueue
    deq_ready = 1'b0;
    push(32'h60); push(32'h64); push(32'h68);
    chk("pre_flush_count", {29'b0, count}, 32'd3);
    set_enq(32'h20);
    flush     = 1'b1;
    deq_ready = 1'b1;
    exp_q.delete();
    tick();
    flush     = 1'b0;
    enq_valid = 1'b0;
    chk("flush_count", {29'b0, count}, 32'd0);
    chk("flush_valid", {31'b0, deq_valid}, 32'd0);
    repeat (3) tick();

    // Stall hold
    deq_ready = 1'b0;
    push(32'h70); push(32'h74);
    hold_e = mk(32'h70);
    for (int i = 0; i < 5; i++) begin
      chk("hold_pc",    deq_pc,   hold_e.pc);
      chk("hold_inst",  deq_inst, hold_e.inst);
      chk("hold_count", {29'b0, count}, 32'd2);
      tick();
    end
    deq_ready = 1'b1;
    repeat (2) tick();
    chk("drain3_count", {29'b0, count}, 32'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Bypass: same-cycle forwarding, entry not written
    set_enq(32'h40);
    deq_ready = 1'b1;
    #1;
    chk("byp_valid", {31'b0, deq_valid}, 32'd1);
    chk("byp_pc",    deq_pc, 32'h40);
    exp_q.push_back(mk(32'h40));
    tick();
    enq_valid = 1'b0;
    chk("byp_count", {29'b0, count}, 32'd0);
`else
    // No bypass: one-cycle enqueue-to-valid latency
    set_enq(32'h40);
    deq_ready = 1'b1;
    #1;
    chk("nobyp_valid0", {31'b0, deq_valid}, 32'd0);
    exp_q.push_back(mk(32'h40));
    tick();
    enq_valid = 1'b0;
    chk("nobyp_count1", {29'b0, count}, 32'd1);
    chk("nobyp_valid1", {31'b0, deq_valid}, 32'd1);
    tick();
    chk("nobyp_count0", {29'b0, count}, 32'd0);
`endif

    tick();
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; both ports are listed first below.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of queued fetch entries: power of two, >= 2.
REQ-003 Parameter XLEN, default 32, SHALL set the inst/pc width (matches `DATA_WIDTH).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous reset, active low.
REQ-006 flush  input  1  predict_fail; discards all queued and incoming entries.
REQ-007 enq_valid  input  1  IF presents an entry; low during icache stall.
REQ-008 enq_ready  output  1  queue can accept an entry.
REQ-009 enq_inst, enq_pc, enq_predict_pc  input  XLEN each  fetched instruction, its PC, predicted target.
REQ-010 enq_predict  input  1  predicted-taken flag.
REQ-011 deq_valid  output  1  head entry valid to ID.
REQ-012 deq_ready  input  1  ID consumes head; low during hazard or dcache stall.
REQ-013 deq_inst, deq_pc, deq_predict_pc  output  XLEN each; deq_predict  output  1  head payload.
REQ-014 count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-015 Enqueue SHALL occur on an edge with enq_valid && enq_ready; dequeue SHALL occur on an edge with deq_valid && deq_ready.
REQ-016 enq_ready SHALL equal (count < DEPTH), registered-state only, with no combinational path from deq_ready.
REQ-017 deq_valid SHALL equal (count != 0) except as modified by REQ-029.
REQ-018 With deq_valid low, all deq payload outputs SHALL be 0, the bubble encoding.
REQ-019 Entries SHALL leave in FIFO order; read/write pointers SHALL wrap modulo DEPTH.
REQ-020 Simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-021 When full, enqueue SHALL be blocked even if a dequeue happens that same edge.
REQ-022 flush SHALL, at the next edge, empty the queue (count=0, pointers=0) and drop any same-cycle enqueue and dequeue.
REQ-023 Priority SHALL be: reset > flush > enqueue/dequeue.
REQ-024 Held entries SHALL keep their payload unchanged while deq_ready is low for any number of cycles.
REQ-025 Without bypass, minimum enqueue-to-deq_valid latency SHALL be 1 cycle.

Reset
REQ-026 On an edge with rst_n low: count=0, pointers=0, deq_valid=0, all deq payload=0, enq_ready=1 in the next cycle.
REQ-027 Reset asserted mid-operation SHALL discard all entries regardless of flush, enq_valid, or deq_ready.
REQ-028 Storage array contents need not be reset; outputs depend only on valid entries.

Configuration
REQ-029 With FETCH_QUEUE_BYPASS_EN defined:
- When count==0, deq_valid SHALL equal enq_valid, and deq payload SHALL equal enq payload combinationally.
- If deq_ready is also high, the entry SHALL not be written and count SHALL stay 0, giving zero latency.
- flush SHALL force deq_valid=0 combinationally.
REQ-030 Without FETCH_QUEUE_BYPASS_EN, no combinational path SHALL exist from enq_* to deq_*.

Structure
REQ-031 A shared package pipe_pkg SHALL hold the typedef fetch_entry_t, a packed struct {inst, pc, predict, predict_pc}, and the bubble constant FETCH_BUBBLE='0.
REQ-032 Storage, pointers and count SHALL be inline; no sub-module is needed.

Verification
REQ-033 The bench SHALL cover these directed scenarios with DEPTH=4 and bypass off:
- Reset: rst_n=0 for 2 cycles -> count=0, deq_valid=0, deq_inst=0, enq_ready=1.
- Order and full: enqueue pc 0x00, 0x04, 0x08, 0x0C with deq_ready=0 -> count=4, enq_ready=0; then deq_ready=1 -> pcs dequeue in order 0x00..0x0C.
- Full with simultaneous enqueue/dequeue: full, enq_valid=1, deq_ready=1 -> only the dequeue occurs, count=3; next cycle enq accepted, count stays 3.
- Flush: 3 entries queued, flush=1 with enq_valid=1 (pc 0x20) -> next cycle count=0, deq_valid=0; pc 0x20 never appears.
- Stall hold: 2 entries, deq_ready=0 for 5 cycles -> deq_pc and deq_inst stable, count=2.
- Bypass on: empty, enq_valid=1 (pc 0x40), deq_ready=1 -> same cycle deq_valid=1, deq_pc=0x40, count stays 0.
